contadores_n: RTL and testbench

//  Parametrised bank of NCH word counters, one per output FIFO, counting pops at the

---
 rtl/contadores_pkg.sv | 17 +
 rtl/contador_canal.sv | 55 +++++
 rtl/contadores_n.sv | 86 ++++++++
 tb/tb_contadores_n.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/contadores_pkg.sv
// Shared constants for the pop-counter bank.
//   MODE_WRAP / MODE_SAT : values for the SAT parameter
//   DEF_NCH / DEF_CW     : default channel count and counter width
//   clog2()              : used to check that IDXW matches NCH at elaboration
package contadores_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;
  localparam int DEF_NCH   = 4;
  localparam int DEF_CW    = 5;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/contador_canal.sv
// One channel of the bank: a CW-bit pop counter plus its sticky overflow flag.
//   clk, rst_l : clock, async active-low reset
//   inc        : one word popped this cycle
//   clr        : clearing read accepted this cycle (takes priority over inc)
//   clr_val    : value loaded on clear (the same-cycle pop, so it is not lost)
//   cnt, ovf   : registered count and sticky overflow flag
module contador_canal
  import contadores_pkg::*;
#(
  parameter int CW  = DEF_CW,
  parameter int SAT = MODE_WRAP
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          inc,
  input  logic          clr,
  input  logic [CW-1:0] clr_val,
  output logic [CW-1:0] cnt,
  output logic          ovf
);
  localparam logic [CW-1:0] MAX = '1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      // Clear wins over a coincident overflow: the flag ends low.
      cnt_d = clr_val;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (cnt_q == MAX) begin
        ovf_d = 1'b1;
        cnt_d = (SAT == MODE_SAT) ? MAX : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/contadores_n.sv
// Bank of NCH pop counters with a prober read port.
//   clk, rst_l : clock, async active-low reset
//   pop        : per-channel pop strobe
//   req, idx   : read request and channel index (honoured only when idle=1)
//   idle       : FSM reports IDLE
//   clr_on_rd  : accepted read also clears the addressed counter
//   data/valid : registered read data and its one-cycle strobe
//   ovf        : sticky per-channel overflow flags
//   rd_err     : one-cycle pulse for a rejected request
module contadores_n
  import contadores_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int CW   = DEF_CW,
  parameter int IDXW = 2,
  parameter int SAT  = MODE_WRAP
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic [NCH-1:0]  pop,
  input  logic            req,
  input  logic [IDXW-1:0] idx,
  input  logic            idle,
  input  logic            clr_on_rd,
  output logic [CW-1:0]   data,
  output logic            valid,
  output logic [NCH-1:0]  ovf,
  output logic            rd_err
);
  if (IDXW != clog2(NCH)) begin : g_bad_idxw
    $error("contadores_n: IDXW must equal clog2(NCH)");
  end
  if (NCH < 2) begin : g_bad_nch
    $error("contadores_n: NCH must be >= 2");
  end
  if (CW < 2) begin : g_bad_cw
    $error("contadores_n: CW must be >= 2");
  end

  // NCH narrowed to IDXW+1 bits so the range check compares equal widths.
  localparam logic [IDXW:0] NCH_W = NCH[IDXW:0];

  logic [NCH-1:0][CW-1:0] cnt;
  logic [NCH-1:0]         clr;
  logic                   accept;

  // Non-power-of-two NCH leaves idx codes with no channel behind them.
  assign accept = req & idle & ({1'b0, idx} < NCH_W);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign clr[i] = accept & clr_on_rd & (idx == IDXW'(i));
    contador_canal #(.CW(CW), .SAT(SAT)) u_ch (
      .clk     (clk),
      .rst_l   (rst_l),
      .inc     (pop[i]),
      .clr     (clr[i]),
      .clr_val ({{(CW-1){1'b0}}, pop[i]}),
      .cnt     (cnt[i]),
      .ovf     (ovf[i])
    );
  end

  logic [CW-1:0] data_q, data_d;
  logic          valid_q, rd_err_q;

  always_comb begin
    data_d = data_q;
    if (accept) data_d = cnt[idx];  // pre-edge value
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      valid_q  <= accept;
      rd_err_q <= req & ~accept;
    end
  end

  assign data   = data_q;
  assign valid  = valid_q;
  assign rd_err = rd_err_q;
endmodule

// File: tb/tb_contadores_n.sv
module tb_contadores_n;
  logic       clk = 1'b0;
  logic       rst_l;
  // main instance: NCH=4, CW=5, wrap
  logic [3:0] pop;
  logic       req, idle, clr_on_rd;
  logic [1:0] idx;
  logic [4:0] data;
  logic       valid, rd_err;
  logic [3:0] ovf;
  // saturating instance
  logic [3:0] s_pop;
  logic       s_req;
  logic [1:0] s_idx;
  logic [4:0] s_data;
  logic       s_valid, s_rd_err;
  logic [3:0] s_ovf;
  // NCH=3 instance
  logic [2:0] t_pop;
  logic       t_req, t_idle;
  logic [1:0] t_idx;
  logic [4:0] t_data;
  logic       t_valid, t_rd_err;
  logic [2:0] t_ovf;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  contadores_n #(.NCH(4), .CW(5), .IDXW(2), .SAT(0)) dut (
    .clk(clk), .rst_l(rst_l), .pop(pop), .req(req), .idx(idx), .idle(idle),
    .clr_on_rd(clr_on_rd), .data(data), .valid(valid), .ovf(ovf), .rd_err(rd_err));

  contadores_n #(.NCH(4), .CW(5), .IDXW(2), .SAT(1)) dut_sat (
    .clk(clk), .rst_l(rst_l), .pop(s_pop), .req(s_req), .idx(s_idx), .idle(1'b1),
    .clr_on_rd(1'b0), .data(s_data), .valid(s_valid), .ovf(s_ovf), .rd_err(s_rd_err));

  contadores_n #(.NCH(3), .CW(5), .IDXW(2), .SAT(0)) dut_n3 (
    .clk(clk), .rst_l(rst_l), .pop(t_pop), .req(t_req), .idx(t_idx), .idle(t_idle),
    .clr_on_rd(1'b0), .data(t_data), .valid(t_valid), .ovf(t_ovf), .rd_err(t_rd_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // inputs set before the call take effect at the next edge; outputs sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pops(input logic [3:0] m, input int n);
    pop = m;
    repeat (n) tick();
    pop = '0;
  endtask

  task automatic rd(input logic [1:0] ch, input logic clr);
    req = 1'b1; idx = ch; idle = 1'b1; clr_on_rd = clr;
    tick();
    req = 1'b0; clr_on_rd = 1'b0;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    #3;
    rst_l = 1'b1;
    #1;
  endtask

  initial begin
    rst_l = 1'b0;
    pop = '0; req = 0; idle = 1; clr_on_rd = 0; idx = '0;
    s_pop = '0; s_req = 0; s_idx = '0;
    t_pop = '0; t_req = 0; t_idle = 1; t_idx = '0;
    #12;
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rderr", rd_err, 0);
    rst_l = 1'b1;
    tick();

    // count / read
    pops(4'b0001, 3);
    pops(4'b0100, 7);
    rd(2'd2, 0);
    chk("rd_ch2_valid", valid, 1);
    chk("rd_ch2_data", data, 7);
    tick();
    chk("valid_one_cycle", valid, 0);
    chk("data_holds", data, 7);
    rd(2'd0, 0); chk("rd_ch0_data", data, 3);
    rd(2'd1, 0); chk("rd_ch1_data", data, 0);

    // wrap: 33 pops -> 1 with overflow
    pops(4'b0010, 33);
    chk("wrap_ovf", ovf, 4'b0010);
    rd(2'd1, 0); chk("wrap_data", data, 1);
    // non-destructive read keeps ovf
    rd(2'd1, 0); chk("wrap_reread", data, 1);
    chk("wrap_ovf_sticky", ovf, 4'b0010);

    // saturate: 40 pops -> 31
    s_pop = 4'b0010;
    repeat (40) tick();
    s_pop = '0;
    chk("sat_ovf", s_ovf, 4'b0010);
    s_req = 1'b1; s_idx = 2'd1;
    tick();
    s_req = 1'b0;
    chk("sat_valid", s_valid, 1);
    chk("sat_data", s_data, 31);

    // gating: idle=0 rejects
    pops(4'b1000, 2);
    req = 1'b1; idx = 2'd3; idle = 1'b0;
    tick();
    req = 1'b0; idle = 1'b1;
    chk("gate_valid", valid, 0);
    chk("gate_rderr", rd_err, 1);
    chk("gate_data_hold", data, 1);
    tick();
    chk("gate_rderr_pulse", rd_err, 0);
    rd(2'd3, 0); chk("gate_cnt3", data, 2);
    chk("gate_ok_rderr", rd_err, 0);
    // out-of-range idx on NCH=3 build
    t_req = 1'b1; t_idx = 2'd3; t_idle = 1'b1;
    tick();
    t_req = 1'b0;
    chk("n3_rderr", t_rd_err, 1);
    chk("n3_valid", t_valid, 0);
    t_req = 1'b1; t_idx = 2'd2;
    tick();
    t_req = 1'b0;
    chk("n3_ok_valid", t_valid, 1);
    chk("n3_ok_rderr", t_rd_err, 0);

    // clear-on-read with same-cycle pop
    do_reset();
    chk("rst2_ovf", ovf, 0);
    pops(4'b0001, 37);   // wraps once, ends at 5
    chk("cor_pre_ovf", ovf, 4'b0001);
    pop = 4'b0001;
    rd(2'd0, 1);
    pop = '0;
    chk("cor_data", data, 5);
    chk("cor_ovf", ovf, 0);
    rd(2'd0, 0); chk("cor_reread", data, 1);
    // overflow coincident with clearing read on the same channel
    pops(4'b0100, 31);
    pop = 4'b0100;
    rd(2'd2, 1);
    pop = '0;
    chk("cor_ovf_data", data, 31);
    chk("cor_ovf_flag", ovf, 0);
    rd(2'd2, 0); chk("cor_ovf_cnt", data, 1);

    // simultaneous pops with back-to-back reads
    do_reset();
    pop = 4'b1111; req = 1'b1; idle = 1'b1;
    for (int k = 0; k < 10; k++) begin
      idx = 2'(k % 4);
      tick();
      chk($sformatf("b2b_valid_%0d", k), valid, 1);
      chk($sformatf("b2b_data_%0d", k), data, k);
    end
    // async reset mid-cycle with pops and req still active
    #3;
    rst_l = 1'b0;
    #1;
    chk("arst_data", data, 0);
    chk("arst_valid", valid, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_rderr", rd_err, 0);
    #1;
    req = 1'b0; pop = '0;
    rst_l = 1'b1;
    tick();
    chk("arst_no_valid", valid, 0);
    for (int c = 0; c < 4; c++) begin
      rd(2'(c), 0);
      chk($sformatf("arst_cnt%0d", c), data, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
